// File: rtl/inst_page_loader_if.sv
// inst_page_loader_if
// Bundles the page-request, DRAM read and instruction-cache write signals of
// the instruction page loader.
//   page_req / page_num          : load request and page number (P register)
//   dram_rd_en / dram_rd_addr    : DRAM read strobe and word address
//   dram_q                       : DRAM read data
//   inst_cache_we / instruction_address / instruction_bus : cache write port
//   paging / done / inst_offset  : CPU stall, completion pulse, resident page base
// Modports: master = requester and DRAM side, slave = the loader itself.
interface inst_page_loader_if #(
  parameter int unsigned CACHE_AWIDTH = 6,
  parameter int unsigned DRAM_AWIDTH  = 15
);
  logic                    page_req;
  logic [15:0]             page_num;
  logic                    dram_rd_en;
  logic [DRAM_AWIDTH-1:0]  dram_rd_addr;
  logic [15:0]             dram_q;
  logic                    inst_cache_we;
  logic [CACHE_AWIDTH-1:0] instruction_address;
  logic [15:0]             instruction_bus;
  logic                    paging;
  logic                    done;
  logic [15:0]             inst_offset;

  modport master (
    output page_req, page_num, dram_q,
    input  dram_rd_en, dram_rd_addr, inst_cache_we, instruction_address,
           instruction_bus, paging, done, inst_offset
  );

  modport slave (
    input  page_req, page_num, dram_q,
    output dram_rd_en, dram_rd_addr, inst_cache_we, instruction_address,
           instruction_bus, paging, done, inst_offset
  );
endinterface

// File: rtl/inst_page_loader.sv
// inst_page_loader
// Instruction-cache page filler. On an accepted page request it reads one page
// of 2^CACHE_AWIDTH words from DRAM (consecutive addresses from the page base,
// wrapping at the top of DRAM) and writes them into the instruction cache in
// index order, holding `paging` high so the CPU stalls. A request for the page
// that is already resident completes in one cycle with no DRAM traffic.
// Ports:
//   clock   : system clock, all state on posedge
//   reset_n : asynchronous active-low reset, aborts any load in progress
//   bus     : inst_page_loader_if slave modport (request, DRAM, cache, status)
module inst_page_loader #(
  parameter int unsigned CACHE_AWIDTH = 6,
  parameter int unsigned DRAM_AWIDTH  = 15,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  inst_page_loader_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [15:0]             page_q, page_d;
  logic [DRAM_AWIDTH-1:0]  base_q, base_d;
  logic [CACHE_AWIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic                    rd_en_q, rd_en_d;
  logic [DRAM_AWIDTH-1:0]  rd_addr_q, rd_addr_d;
  logic                    paging_q, paging_d;
  logic                    done_q, done_d;
  logic [15:0]             offset_q, offset_d;
  logic                    res_valid_q, res_valid_d;
  logic [15:0]             res_page_q, res_page_d;
  // Latency pipeline: stage READ_LATENCY-1 lines up with dram_q.
  logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [CACHE_AWIDTH-1:0] pipe_idx_q [READ_LATENCY];
  logic [CACHE_AWIDTH-1:0] pipe_idx_d [READ_LATENCY];

  logic [DRAM_AWIDTH+15:0] base_wide_s;
  logic [DRAM_AWIDTH-1:0]  req_base_s;
  logic [15:0]             req_offset_s;
  logic [15:0]             cur_offset_s;
  logic                    page_hit_s;
  logic                    wr_en_s;
  logic [CACHE_AWIDTH-1:0] wr_idx_s;
  logic [15:0]             wr_data_s;

  // Page base addresses: DRAM base is truncated to the DRAM width, the
  // published offset keeps the low 16 bits.
  always_comb begin
    base_wide_s  = {{DRAM_AWIDTH{1'b0}}, bus.page_num} << CACHE_AWIDTH;
    req_base_s   = base_wide_s[DRAM_AWIDTH-1:0];
    req_offset_s = bus.page_num << CACHE_AWIDTH;
    cur_offset_s = page_q << CACHE_AWIDTH;
    page_hit_s   = res_valid_q && (res_page_q == bus.page_num);
  end

  // Next-state and next-output logic for the load sequencer and pipeline.
  always_comb begin
    state_d     = state_q;
    page_d      = page_q;
    base_d      = base_q;
    rd_cnt_d    = rd_cnt_q;
    rd_en_d     = rd_en_q;
    rd_addr_d   = rd_addr_q;
    paging_d    = paging_q;
    done_d      = 1'b0;
    offset_d    = offset_q;
    res_valid_d = res_valid_q;
    res_page_d  = res_page_q;

    // Every FETCH cycle issues exactly one read, so its index enters stage 0.
    pipe_vld_d    = {READ_LATENCY{1'b0}};
    pipe_idx_d    = pipe_idx_q;
    pipe_vld_d[0] = (state_q == S_FETCH);
    pipe_idx_d[0] = rd_cnt_q;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_idx_d[i] = pipe_idx_q[i-1];
    end

    case (state_q)
      S_IDLE: begin
        if (bus.page_req) begin
          page_d = bus.page_num;
          base_d = req_base_s;
          if (page_hit_s) begin
            state_d     = S_DONE;
            done_d      = 1'b1;
            offset_d    = req_offset_s;
            res_valid_d = 1'b1;
            res_page_d  = bus.page_num;
          end else begin
            state_d   = S_FETCH;
            rd_cnt_d  = {CACHE_AWIDTH{1'b0}};
            rd_en_d   = 1'b1;
            rd_addr_d = req_base_s;
            paging_d  = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (&rd_cnt_q) begin
          state_d   = S_DRAIN;
          rd_en_d   = 1'b0;
          rd_addr_d = {DRAM_AWIDTH{1'b0}};
        end else begin
          // Address arithmetic wraps naturally at the top of DRAM.
          rd_addr_d = base_q + DRAM_AWIDTH'(rd_cnt_d);
        end
      end
      S_DRAIN: begin
        // Leave once the final write has been presented this cycle.
        if (~|pipe_vld_d) begin
          state_d     = S_DONE;
          paging_d    = 1'b0;
          done_d      = 1'b1;
          offset_d    = cur_offset_s;
          res_valid_d = 1'b1;
          res_page_d  = page_q;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        rd_en_d   = 1'b0;
        rd_addr_d = {DRAM_AWIDTH{1'b0}};
        paging_d  = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous abort on reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      page_q      <= 16'h0000;
      base_q      <= {DRAM_AWIDTH{1'b0}};
      rd_cnt_q    <= {CACHE_AWIDTH{1'b0}};
      rd_en_q     <= 1'b0;
      rd_addr_q   <= {DRAM_AWIDTH{1'b0}};
      paging_q    <= 1'b0;
      done_q      <= 1'b0;
      offset_q    <= 16'h0000;
      res_valid_q <= 1'b0;
      res_page_q  <= 16'h0000;
      pipe_vld_q  <= {READ_LATENCY{1'b0}};
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_idx_q[i] <= {CACHE_AWIDTH{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      page_q      <= page_d;
      base_q      <= base_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      paging_q    <= paging_d;
      done_q      <= done_d;
      offset_q    <= offset_d;
      res_valid_q <= res_valid_d;
      res_page_q  <= res_page_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_idx_q  <= pipe_idx_d;
    end
  end

  // Cache write port: index and data must share the cycle dram_q is valid.
  always_comb begin
    if (pipe_vld_q[READ_LATENCY-1]) begin
      wr_en_s   = 1'b1;
      wr_idx_s  = pipe_idx_q[READ_LATENCY-1];
      wr_data_s = bus.dram_q;
    end else begin
      wr_en_s   = 1'b0;
      wr_idx_s  = {CACHE_AWIDTH{1'b0}};
      wr_data_s = 16'h0000;
    end
  end

  assign bus.dram_rd_en          = rd_en_q;
  assign bus.dram_rd_addr        = rd_addr_q;
  assign bus.inst_cache_we       = wr_en_s;
  assign bus.instruction_address = wr_idx_s;
  assign bus.instruction_bus     = wr_data_s;
  assign bus.paging              = paging_q;
  assign bus.done                = done_q;
  assign bus.inst_offset         = offset_q;

endmodule

// File: tb/tb_inst_page_loader.sv
// Testbench for inst_page_loader: two instances (READ_LATENCY 1 and 3) share
// the same request stimulus; each has its own DRAM model holding
// mem[a] = a ^ 0xA5A5. A transaction-level timing model predicts every output
// of each instance on every cycle.
module tb_inst_page_loader;
  localparam int CAW = 6;
  localparam int DAW = 15;
  localparam int PW  = 64;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        req     = 1'b0;
  logic [15:0] pnum    = 16'h0000;
  int          cyc     = 0;
  int          checks  = 0;
  int          errors  = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  inst_page_loader_if #(.CACHE_AWIDTH(CAW), .DRAM_AWIDTH(DAW)) bus_a ();
  inst_page_loader_if #(.CACHE_AWIDTH(CAW), .DRAM_AWIDTH(DAW)) bus_b ();

  inst_page_loader #(.CACHE_AWIDTH(CAW), .DRAM_AWIDTH(DAW), .READ_LATENCY(1)) dut_a (
    .clock(clock), .reset_n(reset_n), .bus(bus_a.slave));
  inst_page_loader #(.CACHE_AWIDTH(CAW), .DRAM_AWIDTH(DAW), .READ_LATENCY(3)) dut_b (
    .clock(clock), .reset_n(reset_n), .bus(bus_b.slave));

  assign bus_a.page_req = req;
  assign bus_a.page_num = pnum;
  assign bus_b.page_req = req;
  assign bus_b.page_num = pnum;

  function automatic logic [15:0] mem_word(input int a);
    return 16'(a) ^ 16'hA5A5;
  endfunction

  // DRAM models; 16'hDEAD on cycles with no read data.
  logic [15:0] qa = 16'hDEAD;
  logic [15:0] qb [3] = '{16'hDEAD, 16'hDEAD, 16'hDEAD};
  always @(posedge clock) qa <= bus_a.dram_rd_en ? mem_word(int'(bus_a.dram_rd_addr)) : 16'hDEAD;
  always @(posedge clock) begin
    qb[0] <= bus_b.dram_rd_en ? mem_word(int'(bus_b.dram_rd_addr)) : 16'hDEAD;
    qb[1] <= qb[0];
    qb[2] <= qb[1];
  end
  assign bus_a.dram_q = qa;
  assign bus_b.dram_q = qb[2];

  // Reference model: timing derived from the request cycle k.
  typedef struct {
    int          rl;
    bit          active;
    int          k;
    int          base;
    logic [15:0] page;
    bit          hit;
    bit          res_valid;
    logic [15:0] res_page;
    logic [15:0] offset;
    int          done_cyc;
  } model_t;

  model_t ma, mb;

  function automatic void model_reset(inout model_t m);
    m.active = 1'b0; m.k = 0; m.base = 0; m.page = 16'h0; m.hit = 1'b0;
    m.res_valid = 1'b0; m.res_page = 16'h0; m.offset = 16'h0; m.done_cyc = -10;
  endfunction

  function automatic void model_req(inout model_t m, input int k, input logic [15:0] p);
    if (m.active && k <= m.done_cyc) return;  // busy (including DONE cycle)
    m.hit      = m.res_valid && (m.res_page == p);
    m.active   = 1'b1;
    m.k        = k;
    m.page     = p;
    m.base     = (int'(p) * PW) % 32768;
    m.done_cyc = m.hit ? k + 1 : k + PW + 1 + m.rl;
  endfunction

  function automatic void model_step(inout model_t m, input int n);
    if (m.active && n == m.done_cyc) begin
      m.offset    = 16'((int'(m.page) * PW) % 65536);
      m.res_valid = 1'b1;
      m.res_page  = m.page;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_dut(input model_t m, input string tag,
                           input logic rd_en, input logic [14:0] rd_addr,
                           input logic we, input logic [5:0] iaddr, input logic [15:0] ibus,
                           input logic paging, input logic done, input logic [15:0] offs);
    bit rd = 0, wr = 0, pg = 0, dn = 0;
    int ea = 0, ei = 0;
    logic [15:0] ed = 16'h0;
    if (m.active && cyc > m.k) begin
      int j = cyc - m.k - 1;
      int w = j - m.rl;
      if (!m.hit && j < PW) begin rd = 1; ea = (m.base + j) % 32768; end
      if (!m.hit && w >= 0 && w < PW) begin
        wr = 1; ei = w; ed = mem_word((m.base + w) % 32768);
      end
      pg = !m.hit && (j < PW + m.rl);
      dn = (cyc == m.done_cyc);
    end
    chk({tag, ".dram_rd_en"}, 32'(rd_en), 32'(rd));
    chk({tag, ".dram_rd_addr"}, 32'(rd_addr), 32'(ea));
    chk({tag, ".inst_cache_we"}, 32'(we), 32'(wr));
    chk({tag, ".instruction_address"}, 32'(iaddr), 32'(ei));
    chk({tag, ".instruction_bus"}, 32'(ibus), 32'(ed));
    chk({tag, ".paging"}, 32'(paging), 32'(pg));
    chk({tag, ".done"}, 32'(done), 32'(dn));
    chk({tag, ".inst_offset"}, 32'(offs), 32'(m.offset));
  endtask

  // Compare both instances mid-cycle, then move to #1 after the next edge.
  task automatic tick();
    @(negedge clock);
    model_step(ma, cyc);
    model_step(mb, cyc);
    check_dut(ma, "a", bus_a.dram_rd_en, bus_a.dram_rd_addr, bus_a.inst_cache_we,
              bus_a.instruction_address, bus_a.instruction_bus, bus_a.paging,
              bus_a.done, bus_a.inst_offset);
    check_dut(mb, "b", bus_b.dram_rd_en, bus_b.dram_rd_addr, bus_b.inst_cache_we,
              bus_b.instruction_address, bus_b.instruction_bus, bus_b.paging,
              bus_b.done, bus_b.inst_offset);
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [15:0] p);
    pnum = p;
    req  = 1'b1;
    model_req(ma, cyc, p);
    model_req(mb, cyc, p);
    tick();
    req = 1'b0;
  endtask

  task automatic wait_models_idle();
    for (int i = 0; i < 200 && (cyc <= ma.done_cyc || cyc <= mb.done_cyc); i++) tick();
    chk("wait_idle_timeout", 32'(cyc > ma.done_cyc && cyc > mb.done_cyc), 32'd1);
  endtask

  typedef struct {
    logic [15:0] pnum;
    bit          exp_hit;
    logic [15:0] exp_offset;
    logic [14:0] exp_first;
    logic [14:0] exp_last;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int k = cyc;
    int lat_a = -1, lat_b = -1, rd_a = 0, wr_a = 0, pg_a = 0;
    logic [14:0] first_a = 15'h0, last_a = 15'h0;
    bit seen = 0;
    issue(v.pnum);
    for (int i = 0; i < 200 && (lat_a < 0 || lat_b < 0); i++) begin
      if (bus_a.dram_rd_en) begin
        if (!seen) first_a = bus_a.dram_rd_addr;
        seen = 1; last_a = bus_a.dram_rd_addr; rd_a++;
      end
      if (bus_a.inst_cache_we) wr_a++;
      if (bus_a.paging) pg_a++;
      if (bus_a.done && lat_a < 0) lat_a = cyc - k;
      if (bus_b.done && lat_b < 0) lat_b = cyc - k;
      tick();
    end
    chk("vec.latency_a", 32'(lat_a), v.exp_hit ? 32'd1 : 32'd66);
    chk("vec.latency_b", 32'(lat_b), v.exp_hit ? 32'd1 : 32'd68);
    chk("vec.reads_a", 32'(rd_a), v.exp_hit ? 32'd0 : 32'd64);
    chk("vec.writes_a", 32'(wr_a), v.exp_hit ? 32'd0 : 32'd64);
    chk("vec.paging_cycles_a", 32'(pg_a), v.exp_hit ? 32'd0 : 32'd65);
    chk("vec.first_addr_a", 32'(first_a), 32'(v.exp_first));
    chk("vec.last_addr_a", 32'(last_a), 32'(v.exp_last));
    chk("vec.offset_a", 32'(bus_a.inst_offset), 32'(v.exp_offset));
    chk("vec.offset_b", 32'(bus_b.inst_offset), 32'(v.exp_offset));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [6];
    logic [15:0] p;
    int d;
    vecs[0] = '{16'h0002, 1'b0, 16'h0080, 15'h0080, 15'h00BF};
    vecs[1] = '{16'h0002, 1'b1, 16'h0080, 15'h0000, 15'h0000};
    vecs[2] = '{16'h01FF, 1'b0, 16'h7FC0, 15'h7FC0, 15'h7FFF};
    vecs[3] = '{16'h0200, 1'b0, 16'h8000, 15'h0000, 15'h003F};
    vecs[4] = '{16'h0200, 1'b1, 16'h8000, 15'h0000, 15'h0000};
    vecs[5] = '{16'h0002, 1'b0, 16'h0080, 15'h0080, 15'h00BF};

    ma.rl = 1; mb.rl = 3;
    model_reset(ma);
    model_reset(mb);
    @(posedge clock);
    #1;
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Directed table: miss, immediate hit, top-of-DRAM, truncated base.
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Request at write index 10 (instance a) with a new page number is ignored.
    issue(16'h0003);
    for (int i = 0; i < 11; i++) tick();
    chk("midload.write_index", 32'(bus_a.instruction_address), 32'd10);
    issue(16'h0005);
    wait_models_idle();
    chk("midload.offset_a", 32'(bus_a.inst_offset), 32'h00C0);
    chk("midload.offset_b", 32'(bus_b.inst_offset), 32'h00C0);
    run_vec('{16'h0005, 1'b0, 16'h0140, 15'h0140, 15'h017F});

    // Reset at write index 30 aborts the load; same page then misses.
    issue(16'h0007);
    for (int i = 0; i < 31; i++) tick();
    chk("rst.write_index", 32'(bus_a.instruction_address), 32'd30);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst.a_outputs", {bus_a.dram_rd_en, bus_a.inst_cache_we, bus_a.paging, bus_a.done,
                          12'(bus_a.dram_rd_addr), 16'(bus_a.instruction_bus)}, 32'd0);
    chk("rst.a_index_offset", {10'd0, bus_a.instruction_address, bus_a.inst_offset}, 32'd0);
    chk("rst.b_outputs", {bus_b.dram_rd_en, bus_b.inst_cache_we, bus_b.paging, bus_b.done,
                          12'(bus_b.dram_rd_addr), 16'(bus_b.instruction_bus)}, 32'd0);
    chk("rst.b_index_offset", {10'd0, bus_b.instruction_address, bus_b.inst_offset}, 32'd0);
    model_reset(ma);
    model_reset(mb);
    for (int i = 0; i < 3; i++) tick();
    reset_n = 1'b1;
    tick();
    run_vec('{16'h0007, 1'b0, 16'h01C0, 15'h01C0, 15'h01FF});

    // Random request streams, including requests while busy and in DONE.
    for (int r = 0; r < 40; r++) begin
      d = $urandom_range(0, 70);
      for (int i = 0; i < d; i++) tick();
      case ($urandom_range(0, 4))
        0:       p = 16'h0001;
        1:       p = 16'h0002;
        2:       p = 16'h01FF;
        3:       p = 16'h0200;
        default: p = 16'($urandom);
      endcase
      issue(p);
    end
    wait_models_idle();
    for (int i = 0; i < 4; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
